vram_pixel_writer: RTL and testbench

- CPU-side writer for the 256x256 framebuffer that the VGA scan-out block reads.
- Accepts single-pixel plot commands (x, y, 6-bit colour) over a valid/ready handshake.
- Each plot is a read-modify-write of the 16-bit VRAM word that holds two packed pixels.
- Sits between the CPU store path and the VRAM write port.

---
 rtl/vram_pixel_writer.sv | 155 +++++++++++++++
 tb/tb_vram_pixel_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_pixel_writer.sv
// Read-modify-write pixel plotter for a packed 2-pixel-per-word framebuffer.
// Optional screen fill is built only when VRAM_FILL_EN is defined.
module vram_pixel_writer #(
  parameter int          MEM_HEIGHT      = 256,
  parameter int          MEM_WIDTH       = 256,
  parameter logic [15:0] MEM_ADDR_OFFSET = 16'h0000
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [5:0]  cmd_color,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        fill_req,
  input  logic [5:0]  fill_color,
  output logic        fill_done
);

`ifdef VRAM_FILL_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, RD = 3'd1, WAIT = 3'd2, WR = 3'd3, DROP = 3'd4, FILL = 3'd5
  } state_t;
  localparam int          FILL_WORDS = MEM_HEIGHT * MEM_WIDTH / 2;
  localparam logic [15:0] FILL_LAST  = 16'(FILL_WORDS - 1);
  logic [15:0] word_cnt, word_cnt_next;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, RD = 3'd1, WAIT = 3'd2, WR = 3'd3, DROP = 3'd4
  } state_t;
  logic unused_fill;
  assign unused_fill = ^{fill_req, fill_color};
`endif

  state_t      state, state_next;
  logic        lat_odd, lat_odd_next;
  logic [5:0]  lat_color, lat_color_next;
  logic [15:0] addr_next, wdata_next;
  logic        we_next, done_next;
  logic        cmd_in_range;
  logic [15:0] cmd_addr;

  function automatic logic [15:0] merge_pixel(input logic [15:0] old_word,
                                              input logic odd,
                                              input logic [5:0] color);
    if (odd) return {2'b00, color, old_word[7:0]};
    else     return {old_word[15:8], 2'b00, color};
  endfunction

  assign cmd_in_range = (int'({24'd0, cmd_x}) < MEM_WIDTH) &&
                        (int'({24'd0, cmd_y}) < MEM_HEIGHT);
  // Products are taken modulo 2^16, which is exactly the wrap the address needs.
  assign cmd_addr = MEM_ADDR_OFFSET + ({8'd0, cmd_y} * 16'(MEM_WIDTH / 2))
                  + {9'd0, cmd_x[7:1]};

  always_comb begin
    state_next     = state;
    lat_odd_next   = lat_odd;
    lat_color_next = lat_color;
    addr_next      = mem_addr;
    wdata_next     = mem_wdata;
    we_next        = 1'b0;
    done_next      = 1'b0;
`ifdef VRAM_FILL_EN
    word_cnt_next  = word_cnt;
`endif
    case (state)
      IDLE: begin
`ifdef VRAM_FILL_EN
        // A fill request outranks a plot; the plot simply stays pending.
        if (fill_req) begin
          state_next    = FILL;
          addr_next     = MEM_ADDR_OFFSET;
          wdata_next    = {2'b00, fill_color, 2'b00, fill_color};
          we_next       = 1'b1;
          word_cnt_next = 16'd0;
        end else
`endif
        if (cmd_valid) begin
          lat_odd_next   = cmd_x[0];
          lat_color_next = cmd_color;
          if (cmd_in_range) begin
            state_next = RD;
            addr_next  = cmd_addr;
          end else begin
            state_next = DROP;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RD:   state_next = WAIT;
      WAIT: begin
        state_next = WR;
        we_next    = 1'b1;
        wdata_next = merge_pixel(mem_rdata, lat_odd, lat_color);
      end
      WR:   state_next = IDLE;
      DROP: state_next = IDLE;
`ifdef VRAM_FILL_EN
      FILL: begin
        if (word_cnt == FILL_LAST) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          we_next       = 1'b1;
          addr_next     = mem_addr + 16'd1;
          word_cnt_next = word_cnt + 16'd1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= MEM_ADDR_OFFSET;
      mem_wdata <= 16'h0000;
      fill_done <= 1'b0;
      lat_odd   <= 1'b0;
      lat_color <= 6'd0;
`ifdef VRAM_FILL_EN
      word_cnt  <= 16'd0;
`endif
    end else begin
      cmd_ready <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      mem_we    <= we_next;
      mem_addr  <= addr_next;
      mem_wdata <= wdata_next;
      fill_done <= done_next;
      lat_odd   <= lat_odd_next;
      lat_color <= lat_color_next;
`ifdef VRAM_FILL_EN
      word_cnt  <= word_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_vram_pixel_writer.sv
// Scoreboard bench for vram_pixel_writer: a word-array reference model predicts
// every VRAM write (address, data, cycle); a negedge monitor checks them.
module tb_vram_pixel_writer;
  localparam int          W     = 256;
  localparam int          H     = 200;
  localparam logic [15:0] OFF   = 16'h0000;
  localparam int          WORDS = H * W / 2;

  logic        clock = 1'b0;
  logic        clear;
  logic        cmd_valid, cmd_ready, busy, mem_we, fill_req, fill_done;
  logic [7:0]  cmd_x, cmd_y;
  logic [5:0]  cmd_color, fill_color;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] vram    [0:65535];
  logic [15:0] ref_mem [0:65535];
  int          checks = 0;
  int          errors = 0;
  int          fill_done_cnt = 0;
  logic [31:0] cyc = 32'd0;

  vram_pixel_writer #(.MEM_HEIGHT(H), .MEM_WIDTH(W), .MEM_ADDR_OFFSET(OFF)) dut (
    .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .fill_req(fill_req), .fill_color(fill_color),
    .fill_done(fill_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 32'd1;

  function automatic logic [15:0] init_word(input int i);
    if (i == 16'h0082) return 16'hBEEF;
    if (i == 0)        return 16'h1234;
    return 16'((i * 40503 + 12345) ^ (i >> 3));
  endfunction

  // VRAM model: one-cycle synchronous read, write on mem_we.
  initial begin
    for (int i = 0; i < 65536; i++) vram[i] = init_word(i);
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clock);
      if (mem_we) vram[mem_addr] <= mem_wdata;
      mem_rdata <= vram[mem_addr];
    end
  end

  // Monitor: every write strobe must match the oldest prediction.
  always @(negedge clock) begin
    if (clear === 1'b0) begin
      checks++;
      if (busy !== ~cmd_ready) begin
        errors++;
        $display("FAIL busy_vs_ready: busy=%b cmd_ready=%b cyc=%0d", busy, cmd_ready, cyc);
      end
      if (fill_done === 1'b1) fill_done_cnt++;
      if (mem_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%h data=%h cyc=%0d", mem_addr, mem_wdata, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data || cyc !== mon_e.cyc) begin
            errors++;
            $display("FAIL write: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                     mem_addr, mem_wdata, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, 16'(cmd_ready), 16'h0001);
    chk({tag, "_busy"},      16'(busy),      16'h0000);
    chk({tag, "_mem_we"},    16'(mem_we),    16'h0000);
    chk({tag, "_mem_addr"},  mem_addr,       OFF);
    chk({tag, "_mem_wdata"}, mem_wdata,      16'h0000);
    chk({tag, "_fill_done"}, 16'(fill_done), 16'h0000);
  endtask

  // Reference model: update one pixel of the word array, return the new word.
  task automatic model_plot(input logic [7:0] x, input logic [7:0] y, input logic [5:0] c,
                            input logic [31:0] acc_cyc);
    int          wa;
    logic [15:0] old_w, new_w;
    wa    = (int'(OFF) + int'(y) * (W / 2) + int'(x) / 2) % 65536;
    old_w = ref_mem[wa];
    if (x % 2 == 1) new_w = (old_w & 16'h00FF) | (16'(c) << 8);
    else            new_w = (old_w & 16'hFF00) | 16'(c);
    ref_mem[wa] = new_w;
    exp_q.push_back('{16'(wa), new_w, acc_cyc + 32'd3});
  endtask

  task automatic plot(input logic [7:0] x, input logic [7:0] y, input logic [5:0] c,
                      input bit hold);
    int          n;
    logic [31:0] a0;
    int          lat;
    cmd_x = x; cmd_y = y; cmd_color = c; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (n >= 64) begin
      chk("plot_accept_timeout", 16'(cmd_ready), 16'h0001);
      cmd_valid = 1'b0;
      return;
    end
    a0 = cyc;
    if (int'(x) < W && int'(y) < H) begin
      model_plot(x, y, c, a0);
      lat = 4;
    end else begin
      lat = 2;
    end
    @(posedge clock);
    #1;
    if (!hold) cmd_valid = 1'b0;
    @(negedge clock);
    while (cmd_ready !== 1'b1 && cyc - a0 < 32'd16) @(negedge clock);
    chk("ready_latency", 16'(cyc - a0), 16'(lat));
  endtask

  initial begin
    logic [7:0] px, py;
    clear = 1'b1; cmd_valid = 1'b0; cmd_x = 8'd0; cmd_y = 8'd0; cmd_color = 6'd0;
    fill_req = 1'b0; fill_color = 6'd0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    clear = 1'b0;
    @(negedge clock);

    plot(8'd4, 8'd1, 6'h2A, 1'b0);
    plot(8'd5, 8'd0, 6'h3F, 1'b0);
    plot(8'd10, 8'd220, 6'h15, 1'b0);
    plot(8'd4, 8'd1, 6'h11, 1'b1);
    plot(8'd5, 8'd1, 6'h22, 1'b1);
    plot(8'd200, 8'd199, 6'h33, 1'b0);

    // Abort during WAIT: no write, outputs return to reset values.
    cmd_x = 8'd8; cmd_y = 8'd3; cmd_color = 6'h3C; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1) @(negedge clock);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(posedge clock);
    #2 clear = 1'b1;
    #1 check_reset_values("abort");
    @(negedge clock);
    clear = 1'b0;
    repeat (4) @(negedge clock);
    plot(8'd8, 8'd3, 6'h07, 1'b0);

    px = 8'd0; py = 8'd0;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        px = px ^ 8'd1;
      end else begin
        px = 8'($urandom_range(0, 255));
        py = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(H, 255))
                                         : 8'($urandom_range(0, H - 1));
      end
      plot(px, py, 6'($urandom_range(0, 63)), ($urandom_range(0, 1) == 1) && k != 39);
      if (cmd_valid === 1'b0) repeat ($urandom_range(0, 2)) @(negedge clock);
    end

`ifdef VRAM_FILL_EN
    begin
      logic [31:0] f0;
      logic [5:0]  fc;
      fc = 6'($urandom_range(0, 63));
      while (cmd_ready !== 1'b1) @(negedge clock);
      fill_color = fc; fill_req = 1'b1;
      cmd_x = 8'd3; cmd_y = 8'd7; cmd_color = 6'h2D; cmd_valid = 1'b1;
      f0 = cyc;
      for (int i = 0; i < WORDS; i++) begin
        ref_mem[(int'(OFF) + i) % 65536] = 16'(int'(fc) * 257);
        exp_q.push_back('{16'(int'(OFF) + i), 16'(int'(fc) * 257), f0 + 32'd1 + 32'(i)});
      end
      model_plot(8'd3, 8'd7, 6'h2D, f0 + 32'(WORDS) + 32'd1);
      @(posedge clock);
      #1 fill_req = 1'b0; fill_color = ~fc;
      @(negedge clock);
      while (cmd_ready !== 1'b1 && cyc - f0 < 32'(WORDS + 16)) @(negedge clock);
      chk("fill_end_cycle", 16'(cyc - f0 - 32'(WORDS)), 16'd1);
      chk("fill_done_pulse", 16'(fill_done), 16'h0001);
      @(posedge clock);
      #1 cmd_valid = 1'b0;
      repeat (6) @(negedge clock);
      chk("fill_done_count", 16'(fill_done_cnt), 16'd1);
    end
    for (int k = 0; k < 6; k++)
      plot(8'($urandom_range(0, 255)), 8'($urandom_range(0, H - 1)), 6'($urandom_range(0, 63)), 1'b0);
`else
    fill_req = 1'b1; fill_color = 6'h15;
    plot(8'd6, 8'd2, 6'h19, 1'b0);
    fill_req = 1'b0;
    chk("fill_done_count", 16'(fill_done_cnt), 16'd0);
`endif

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clock);
    chk("pending_writes", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
